// File: rtl/fifo_sync_reader.sv
// Read-side drain controller for fifo_sync: pops words with registered read latency
// and presents them on a valid/ready stream through a 3-entry credit buffer.
module fifo_sync_reader #(
  parameter int DATA_WIDTH  = 4,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   fifo_empty,
  input  logic [DATA_WIDTH-1:0]  fifo_rd,
  output logic                   fifo_r_en,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] words_read
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] slot [3];
  logic [1:0]            head, tail, occ;
  logic                  pending;
  logic [2:0]            credit_used;
  logic                  capture, accept;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Credit counts the in-flight word too, so r_en never depends on m_ready.
  assign credit_used = {1'b0, occ} + {2'b0, pending};
  assign fifo_r_en   = en & ~fifo_empty & ~rst & (credit_used < 3'd3);

  assign capture    = pending;
  assign accept     = m_valid & m_ready;
  assign m_valid    = (occ != 2'd0);
  assign m_data     = slot[head];
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      occ        <= '0;
      pending    <= 1'b0;
      head       <= '0;
      tail       <= '0;
      words_read <= '0;
      for (int unsigned i = 0; i < 3; i++) slot[i] <= '0;
    end else begin
      state   <= state_next;
      pending <= fifo_r_en;
      if (capture) begin
        slot[tail] <= fifo_rd;
        tail       <= ptr_inc(tail);
      end
      if (accept) begin
        head       <= ptr_inc(head);
        words_read <= words_read + COUNT_WIDTH'(1);
      end
      case ({capture, accept})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (en) state_next = RUN;
      RUN:   if (!en) state_next = (pending || occ != 2'd0) ? DRAIN : IDLE;
      DRAIN: begin
        if (en)                             state_next = RUN;
        else if (!pending && occ == 2'd0)   state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_sync_reader.sv
// Bench for fifo_sync_reader: behavioural FIFO source, queue-based reference model,
// a table-driven basic drain, directed corner sequences and a randomized stream.
module tb_fifo_sync_reader;
  localparam int DW = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_rd = '0;
  logic          fifo_r_en;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          busy;
  logic [CW-1:0] words_read;

  fifo_sync_reader #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
    .fifo_r_en(fifo_r_en), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .words_read(words_read)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Source FIFO (depth 4, registered read) and its controls
  logic [DW-1:0] fq[$];
  bit            push = 1'b0;
  logic [DW-1:0] push_data = '0;
  bit            fifo_rst = 1'b1;

  // Reference model: buffered words, in-flight word, accept count, activity flag
  logic [DW-1:0] mq[$];
  bit            m_inflight = 1'b0;
  logic [DW-1:0] m_inflight_word = '0;
  int unsigned   m_words = 0;
  bit            m_busy = 1'b0;

  typedef struct {
    bit           en;
    bit           rdy;
    bit           ren;
    bit           valid;
    logic [DW-1:0] data;
    bit           busy;
    logic [CW-1:0] words;
  } vec_t;
  vec_t tab[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input bit e, input bit r, input bit p, input logic [DW-1:0] d,
                       input bit rs = 1'b0, input bit frs = 1'b0);
    en = e; m_ready = r; push = p; push_data = d; rst = rs; fifo_rst = frs;
    @(negedge clk);
  endtask

  // Called at the negedge: compare against the model, then advance one edge.
  task automatic step();
    bit exp_ren, acc, pop_dut, busy_n;
    exp_ren = en && !fifo_empty && !rst && ((mq.size() + int'(m_inflight)) < 3);
    chk("r_en", fifo_r_en, exp_ren);
    chk("m_valid", m_valid, mq.size() != 0);
    if (mq.size() != 0) chk("m_data", m_data, mq[0]);
    chk("words_read", words_read, m_words & 32'hFF);
    chk("busy", busy, m_busy);
    chk("pop_on_empty", fifo_r_en && fifo_empty, 0);
    chk("credit", ({1'b0, dut.occ} + {2'b0, dut.pending}) <= 3'd3, 1);
    acc     = (mq.size() != 0) && m_ready;
    pop_dut = fifo_r_en;
    @(posedge clk);
    #1;
    if (rst) begin
      mq.delete(); m_inflight = 1'b0; m_words = 0; m_busy = 1'b0;
    end else begin
      busy_n = en ? 1'b1 : (m_busy && (m_inflight || mq.size() != 0));
      if (acc) begin void'(mq.pop_front()); m_words++; end
      if (m_inflight) mq.push_back(m_inflight_word);
      m_inflight = exp_ren;
      if (exp_ren) m_inflight_word = fq[0];
      m_busy = busy_n;
    end
    if (fifo_rst) begin
      fq.delete(); fifo_rd = '0;
    end else begin
      if (pop_dut && fq.size() > 0) fifo_rd = fq.pop_front();
      if (push && fq.size() < 4) fq.push_back(push_data);
    end
    fifo_empty = (fq.size() == 0);
  endtask

  initial begin
    int pops, acc_cnt, got_n;
    bit seen_ff, wrapped;
    logic [DW-1:0] got[$];
    logic [DW-1:0] expv;

    tab[0] = '{1, 1, 1, 0, 4'h0, 0, 8'd0};
    tab[1] = '{1, 1, 1, 0, 4'h0, 1, 8'd0};
    tab[2] = '{1, 1, 1, 1, 4'h1, 1, 8'd0};
    tab[3] = '{1, 1, 0, 1, 4'h2, 1, 8'd1};
    tab[4] = '{1, 1, 0, 1, 4'h3, 1, 8'd2};
    tab[5] = '{1, 1, 0, 0, 4'h0, 1, 8'd3};
    tab[6] = '{0, 1, 0, 0, 4'h0, 1, 8'd3};
    tab[7] = '{0, 1, 0, 0, 4'h0, 0, 8'd3};

    // Reset and reset-state values
    for (int i = 0; i < 2; i++) begin apply(1, 1, 0, '0, 1, 1); step(); end
    apply(0, 1, 1, 4'h1);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_words", words_read, 0);
    chk("rst_busy", busy, 0);
    step();

    // Test 1: preload 1,2,3 then table-driven drain
    apply(0, 1, 1, 4'h2); step();
    apply(0, 1, 1, 4'h3); step();
    for (int i = 0; i < 8; i++) begin
      apply(tab[i].en, tab[i].rdy, 0, '0);
      chk($sformatf("t1_ren[%0d]", i), fifo_r_en, tab[i].ren);
      chk($sformatf("t1_valid[%0d]", i), m_valid, tab[i].valid);
      if (tab[i].valid) chk($sformatf("t1_data[%0d]", i), m_data, tab[i].data);
      chk($sformatf("t1_busy[%0d]", i), busy, tab[i].busy);
      chk($sformatf("t1_words[%0d]", i), words_read, tab[i].words);
      step();
    end

    // Test 2: full FIFO, stalled consumer -> exactly 3 pops, head held
    for (int i = 0; i < 4; i++) begin apply(0, 0, 1, DW'(4'hA + i)); step(); end
    pops = 0;
    for (int i = 0; i < 6; i++) begin
      apply(1, 0, 0, '0);
      if (fifo_r_en) pops++;
      if (i >= 2) chk("t2_head_stable", m_data, 4'hA);
      step();
    end
    chk("t2_pops", pops, 3);
    chk("t2_occ", dut.occ, 3);
    got.delete();
    for (int i = 0; i < 12; i++) begin
      apply(1, 1, 0, '0);
      if (i == 0) chk("t2_no_pop_before_accept", fifo_r_en, 0);
      if (m_valid) got.push_back(m_data);
      step();
    end
    got_n = got.size();
    chk("t2_count", got_n, 4);
    for (int i = 0; i < 4 && i < got_n; i++) begin
      expv = DW'(4'hA + i);
      chk($sformatf("t2_order[%0d]", i), got[i], expv);
    end
    for (int i = 0; i < 3; i++) begin apply(0, 1, 0, '0); step(); end

    // Test 3: continuous stream, one accept per cycle in steady state
    acc_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      apply(1, 1, 1, DW'($urandom));
      if (i >= 10 && m_valid) acc_cnt++;
      step();
    end
    chk("t3_rate", acc_cnt, 30);
    for (int i = 0; i < 5; i++) begin apply(0, 1, 0, '0); step(); end
    chk("t3_idle", busy, 0);

    // Test 4: drop en with occ=1, pending=1
    for (int i = 0; i < 3; i++) begin apply(0, 0, 1, DW'(4'h5 + i)); step(); end
    for (int i = 0; i < 2; i++) begin apply(1, 0, 0, '0); step(); end
    apply(0, 0, 0, '0);
    chk("t4_occ", dut.occ, 1);
    chk("t4_pending", dut.pending, 1);
    step();
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 0, '0);
      chk("t4_no_pop", fifo_r_en, 0);
      chk("t4_draining", busy, 1);
      step();
    end
    acc_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      apply(0, 1, 0, '0);
      if (m_valid) acc_cnt++;
      step();
    end
    chk("t4_delivered", acc_cnt, 2);
    chk("t4_idle", busy, 0);

    // Test 5: words_read wrap 0xFF -> 0x00, then randomized traffic
    seen_ff = 1'b0; wrapped = 1'b0;
    for (int i = 0; i < 600; i++) begin
      apply(1, 1, 1, DW'($urandom));
      if (seen_ff) begin
        chk("t5_wrap", words_read, 0);
        wrapped = 1'b1;
        step();
        break;
      end
      if (words_read == 8'hFF && m_valid) seen_ff = 1'b1;
      step();
    end
    chk("t5_wrap_reached", wrapped, 1);
    for (int i = 0; i < 400; i++) begin
      apply($urandom_range(0, 7) != 0, $urandom_range(0, 1) != 0,
            $urandom_range(0, 3) != 0, DW'($urandom));
      step();
    end
    for (int i = 0; i < 6; i++) begin apply(0, 1, 0, '0); step(); end

    // Test 6: reset with occ=2, pending=1
    for (int i = 0; i < 4; i++) begin apply(0, 0, 1, DW'($urandom)); step(); end
    for (int i = 0; i < 3; i++) begin apply(1, 0, 0, '0); step(); end
    apply(1, 0, 0, '0, 1, 1);
    chk("t6_occ", dut.occ, 2);
    chk("t6_pending", dut.pending, 1);
    chk("t6_ren_in_rst", fifo_r_en, 0);
    step();
    apply(0, 0, 0, '0);
    chk("t6_m_valid", m_valid, 0);
    chk("t6_m_data", m_data, 0);
    chk("t6_words", words_read, 0);
    chk("t6_busy", busy, 0);
    step();
    apply(0, 0, 1, 4'h9); step();
    apply(1, 1, 0, '0, 1, 0);
    chk("t6_ren_gated_by_rst", fifo_r_en, 0);
    step();
    for (int i = 0; i < 6; i++) begin apply(1, 1, 0, '0); step(); end
    for (int i = 0; i < 3; i++) begin apply(0, 1, 0, '0); step(); end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/fifo_sync_reader.md
Name: fifo_sync_reader

Overview:
Read-side drain controller for the team's synchronous FIFO. It pops words through the FIFO read port (r_en/RD/EMPTY) and presents them downstream on a valid/ready stream. The FIFO's read data is registered, so the controller tracks the one-cycle read latency. It holds popped words in a 3-entry credit buffer so that no combinational path runs from downstream ready to the FIFO r_en. It sits between fifo_sync and any consumer that can stall.

Parameters:
DATA_WIDTH, 4, word width; must equal the FIFO MEMORY_WIDTH.
COUNT_WIDTH, 8, width of the popped-word counter.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst  input  1  synchronous, active-high reset; shared with the FIFO.
en  input  1  high permits new pops; low stops new pops, and in-flight and buffered words still drain.
fifo_empty  input  1  FIFO EMPTY flag.
fifo_rd  input  DATA_WIDTH  FIFO RD bus; valid in the cycle after a pop edge.
fifo_r_en  output  1  FIFO r_en; combinational.
m_data  output  DATA_WIDTH  head-of-buffer word.
m_valid  output  1  buffer non-empty.
m_ready  input  1  downstream accepts m_data when m_valid & m_ready at an edge.
busy  output  1  state != IDLE.
words_read  output  COUNT_WIDTH  count of words accepted downstream; wraps.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: occ=0, pending=0, state=IDLE, m_valid=0, m_data=0, busy=0, words_read=0. fifo_r_en is forced to 0 while rst=1.
- Pop rule: fifo_r_en = en & !fifo_empty & !rst & (occ + pending < 3). This uses only registered state, so there is no m_ready-to-r_en path.
- A pop happens at an edge where fifo_r_en=1. At that edge pending is set to 1.
- In the next cycle fifo_rd holds the popped word. At the following edge that word is written to the buffer tail. pending clears unless a new pop happens at the same edge.
- Latency: pop edge to m_valid=1 is 2 edges when the buffer is empty.
- Buffer: 3-entry in-order FIFO (head/tail pointers mod 3, occ 0..3).
  - Capture only: occ+1.
  - Accept only (m_valid & m_ready): occ-1.
  - Capture and accept at the same edge: occ unchanged, and the head and tail pointers both advance.
  - The credit rule guarantees occ + pending <= 3, so there is never a capture into a full buffer. The bench asserts this.
- m_data is the head entry. It holds stable while m_valid & !m_ready. m_valid = (occ != 0).
- Throughput: with m_ready held at 1 and the FIFO non-empty, the block makes one pop and one accept per cycle in steady state.
- words_read increments by 1 on each accept and wraps from 2^COUNT_WIDTH-1 to 0.
- FSM (registered):
  - IDLE -> RUN when en=1.
  - RUN -> DRAIN when en=0 and (pending | occ != 0).
  - RUN -> IDLE when en=0 and pending=0 and occ=0.
  - DRAIN -> RUN when en=1.
  - DRAIN -> IDLE when pending=0 and occ=0 and en=0.
  - Pops are only issued in RUN, or at the IDLE/DRAIN edge where en is sampled high. The rule above already gates on en.
- fifo_empty is sampled only through the pop rule. A word written to the FIFO and simultaneously visible as !EMPTY is popped at the next eligible edge.
- Reset mid-operation: the buffered word and the in-flight word are discarded. No accept is counted at the reset edge. The FIFO resets concurrently.

Test Plan:
1. Reset, then preload FIFO with 0x1,0x2,0x3, en=1, m_ready=1 -> fifo_r_en high 3 consecutive cycles; m_data 0x1,0x2,0x3 on consecutive cycles starting 2 edges after first pop; words_read=3; busy returns to 0 only after en=0.
2. FIFO full (4 words 0xA..0xD), m_ready=0, en=1 -> exactly 3 pops, then fifo_r_en=0; occ=3; m_data=0xA stable; then m_ready=1 -> 0xA,0xB,0xC,0xD in order, the 4th word popped after the first accept.
3. Continuous stream: FIFO written every cycle, m_ready=1 -> one accept per cycle, never a fifo_r_en while fifo_empty=1, occ+pending<=3 always.
4. en dropped with pending=1, occ=1 -> no further pops; state DRAIN; 2 remaining words delivered; then IDLE, busy=0.
5. words_read at 0xFF plus one accept -> 0x00. m_ready toggled randomly -> no drops, no duplicates versus a scoreboard.
6. rst asserted for 1 cycle with occ=2 and pending=1 -> next cycle m_valid=0, m_data=0, words_read=0, fifo_r_en=0 during rst, state IDLE.
